// File: rtl/avg_fetch_decode.sv
// avg_fetch_decode
// Instruction fetch and decode engine for the Analog Vector Generator.
// Walks the display list in vector memory, assembles 1- or 2-word
// instructions, resolves JMP/JSR/RTS on an internal return stack and hands
// drawing/state instructions to the vector executor over valid/ready.
//
// Optional feature macro: AVG_DEC_STACK_CHECK_EN
//   defined   : JSR on a full stack or RTS on an empty stack raises the
//               sticky err flag and halts the engine.
//   undefined : the stack pointer wraps modulo STACK_DEPTH and err is 0.

module avg_fetch_decode #(
    parameter int ADDR_W      = 13,
    parameter int DELTA_W     = 13,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               go,
    input  logic [ADDR_W-1:0]  start_addr,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [15:0]        mem_rdata,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [2:0]         dec_op,
    output logic [DELTA_W-1:0] dec_dx,
    output logic [DELTA_W-1:0] dec_dy,
    output logic [3:0]         dec_z,
    output logic               dec_blank,
    output logic               dec_usez,
    output logic [2:0]         dec_color,
    output logic [7:0]         dec_lin,
    output logic [2:0]         dec_bin,
    output logic               dec_scal,
    output logic               busy,
    output logic               halted,
    output logic               err
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
`ifdef AVG_DEC_STACK_CHECK_EN
    // One extra bit so the pointer can represent a completely full stack.
    localparam int SP_W = IDX_W + 1;
`else
    localparam int SP_W = IDX_W;
`endif

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH0 = 3'd1;
    localparam logic [2:0] ST_FETCH1 = 3'd2;
    localparam logic [2:0] ST_ISSUE  = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;

    localparam logic [2:0] OP_VCTR = 3'd0;
    localparam logic [2:0] OP_HALT = 3'd1;
    localparam logic [2:0] OP_SVEC = 3'd2;
    localparam logic [2:0] OP_STAT = 3'd3;
    localparam logic [2:0] OP_CNTR = 3'd4;
    localparam logic [2:0] OP_JSR  = 3'd5;
    localparam logic [2:0] OP_RTS  = 3'd6;
    localparam logic [2:0] OP_JMP  = 3'd7;

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   sp_inc;
    logic [SP_W-1:0]   sp_dec;
    logic [12:0]       dy_hold;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];

    logic [2:0]        op_word;
    logic [ADDR_W-1:0] jump_target;
    logic              stack_fault;
    logic              push;

    logic [DELTA_W-1:0] nx_dx;
    logic [DELTA_W-1:0] nx_dy;
    logic [3:0]         nx_z;
    logic               nx_blank;
    logic               nx_usez;
    logic [2:0]         nx_color;
    logic [7:0]         nx_lin;
    logic [2:0]         nx_bin;
    logic               nx_scal;
    logic [2:0]         z3;
    logic               use_z3;

    function automatic logic [DELTA_W-1:0] sext13(input logic [12:0] v);
        return DELTA_W'(signed'(v));
    endfunction

    function automatic logic [DELTA_W-1:0] sext5x2(input logic [4:0] v);
        logic [DELTA_W-1:0] t;
        t = DELTA_W'(signed'(v));
        return t << 1;
    endfunction

    assign op_word = mem_rdata[15:13];
    assign pc_inc  = pc + 1'b1;
    assign sp_inc  = sp + 1'b1;
    assign sp_dec  = sp - 1'b1;
    assign busy    = (state == ST_FETCH0) || (state == ST_FETCH1) || (state == ST_ISSUE);
    assign halted  = (state == ST_HALTED);

    generate
        if (ADDR_W > 13) begin : g_wide_target
            assign jump_target = {{(ADDR_W-13){1'b0}}, mem_rdata[12:0]};
        end else begin : g_narrow_target
            assign jump_target = mem_rdata[ADDR_W-1:0];
        end
    endgenerate

`ifdef AVG_DEC_STACK_CHECK_EN
    logic err_q;
    assign err = err_q;
    assign stack_fault = ((op_word == OP_JSR) && (sp == SP_W'(STACK_DEPTH))) ||
                         ((op_word == OP_RTS) && (sp == '0));
`else
    assign err = 1'b0;
    assign stack_fault = 1'b0;
`endif

    assign push = (state == ST_FETCH0) && mem_ack && (op_word == OP_JSR) && !stack_fault;

    // Decode the word(s) arriving from memory into next executor fields.
    always_comb begin
        nx_dx    = dec_dx;
        nx_dy    = dec_dy;
        nx_z     = dec_z;
        nx_blank = dec_blank;
        nx_usez  = dec_usez;
        nx_color = dec_color;
        nx_lin   = dec_lin;
        nx_bin   = dec_bin;
        nx_scal  = dec_scal;
        z3       = 3'd0;
        use_z3   = 1'b0;
        if (state == ST_FETCH1) begin
            nx_dy  = sext13(dy_hold);
            nx_dx  = sext13(mem_rdata[12:0]);
            z3     = mem_rdata[15:13];
            use_z3 = 1'b1;
        end else begin
            case (op_word)
                OP_SVEC: begin
                    nx_dy  = sext5x2(mem_rdata[12:8]);
                    nx_dx  = sext5x2(mem_rdata[4:0]);
                    z3     = mem_rdata[7:5];
                    use_z3 = 1'b1;
                end
                OP_STAT: begin
                    if (mem_rdata[12]) begin
                        nx_scal = 1'b1;
                        nx_bin  = mem_rdata[10:8];
                        nx_lin  = mem_rdata[7:0];
                    end else begin
                        nx_scal  = 1'b0;
                        nx_z     = mem_rdata[7:4];
                        nx_color = mem_rdata[2:0];
                    end
                end
                default: begin
                end
            endcase
        end
        if (use_z3) begin
            nx_blank = (z3 == 3'd0);
            nx_usez  = (z3 == 3'd1);
            nx_z     = (z3 >= 3'd2) ? {z3, 1'b0} : 4'd0;
        end
    end

    // Return stack storage; written on every accepted JSR.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[sp[IDX_W-1:0]] <= pc_inc;
        end
    end

    // Sequencer: fetch, resolve control flow, issue and halt.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state     <= ST_IDLE;
            pc        <= '0;
            sp        <= '0;
            dy_hold   <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            dec_valid <= 1'b0;
            dec_op    <= 3'd0;
            dec_dx    <= '0;
            dec_dy    <= '0;
            dec_z     <= 4'd0;
            dec_blank <= 1'b0;
            dec_usez  <= 1'b0;
            dec_color <= 3'b010;
            dec_lin   <= 8'd0;
            dec_bin   <= 3'd0;
            dec_scal  <= 1'b0;
`ifdef AVG_DEC_STACK_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (go) begin
                        state    <= ST_FETCH0;
                        pc       <= start_addr;
                        sp       <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= start_addr;
`ifdef AVG_DEC_STACK_CHECK_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                ST_FETCH0: begin
                    if (mem_ack) begin
                        case (op_word)
                            OP_VCTR: begin
                                state    <= ST_FETCH1;
                                dy_hold  <= mem_rdata[12:0];
                                pc       <= pc_inc;
                                mem_addr <= pc_inc;
                            end
                            OP_JMP: begin
                                pc       <= jump_target;
                                mem_addr <= jump_target;
                            end
                            OP_JSR, OP_RTS: begin
                                if (stack_fault) begin
                                    state   <= ST_HALTED;
                                    mem_req <= 1'b0;
`ifdef AVG_DEC_STACK_CHECK_EN
                                    err_q   <= 1'b1;
`endif
                                end else if (op_word == OP_JSR) begin
                                    sp       <= sp_inc;
                                    pc       <= jump_target;
                                    mem_addr <= jump_target;
                                end else begin
                                    sp       <= sp_dec;
                                    pc       <= stack[sp_dec[IDX_W-1:0]];
                                    mem_addr <= stack[sp_dec[IDX_W-1:0]];
                                end
                            end
                            default: begin
                                state     <= ST_ISSUE;
                                mem_req   <= 1'b0;
                                pc        <= pc_inc;
                                dec_valid <= 1'b1;
                                dec_op    <= op_word;
                                dec_dx    <= nx_dx;
                                dec_dy    <= nx_dy;
                                dec_z     <= nx_z;
                                dec_blank <= nx_blank;
                                dec_usez  <= nx_usez;
                                dec_color <= nx_color;
                                dec_lin   <= nx_lin;
                                dec_bin   <= nx_bin;
                                dec_scal  <= nx_scal;
                            end
                        endcase
                    end
                end
                ST_FETCH1: begin
                    if (mem_ack) begin
                        state     <= ST_ISSUE;
                        mem_req   <= 1'b0;
                        pc        <= pc_inc;
                        dec_valid <= 1'b1;
                        dec_op    <= OP_VCTR;
                        dec_dx    <= nx_dx;
                        dec_dy    <= nx_dy;
                        dec_z     <= nx_z;
                        dec_blank <= nx_blank;
                        dec_usez  <= nx_usez;
                    end
                end
                ST_ISSUE: begin
                    if (dec_ready) begin
                        dec_valid <= 1'b0;
                        if (dec_op == OP_HALT) begin
                            state <= ST_HALTED;
                        end else begin
                            state    <= ST_FETCH0;
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avg_fetch_decode.sv
// tb_avg_fetch_decode
// Scoreboard bench for avg_fetch_decode: directed display lists sit in a
// behavioural memory that acknowledges one cycle after seeing a request.
// Expected issues are queued when a program is launched and a monitor pops
// and compares them whenever the executor handshake completes.
// Honours AVG_DEC_STACK_CHECK_EN for the stack-fault expectations.

module tb_avg_fetch_decode;

    localparam int ADDR_W  = 13;
    localparam int DELTA_W = 13;
    localparam int DEPTH   = 4;

    typedef struct {
        int          id;
        logic [2:0]  op;
        logic [12:0] dx;
        logic [12:0] dy;
        logic [3:0]  z;
        logic        blank;
        logic        usez;
        logic [2:0]  color;
        logic [7:0]  lin;
        logic [2:0]  bin;
        logic        scal;
    } exp_t;

    logic               clk;
    logic               rst_b;
    logic               go;
    logic [ADDR_W-1:0]  start_addr;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [15:0]        mem_rdata;
    logic               dec_valid;
    logic               dec_ready;
    logic [2:0]         dec_op;
    logic [DELTA_W-1:0] dec_dx;
    logic [DELTA_W-1:0] dec_dy;
    logic [3:0]         dec_z;
    logic               dec_blank;
    logic               dec_usez;
    logic [2:0]         dec_color;
    logic [7:0]         dec_lin;
    logic [2:0]         dec_bin;
    logic               dec_scal;
    logic               busy;
    logic               halted;
    logic               err;

    logic [15:0]        mem [0:8191];
    exp_t               exp_q [$];
    logic [ADDR_W-1:0]  addr_log [$];
    int                 checks = 0;
    int                 failures = 0;

    avg_fetch_decode #(
        .ADDR_W(ADDR_W),
        .DELTA_W(DELTA_W),
        .STACK_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_b(rst_b),
        .go(go),
        .start_addr(start_addr),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .dec_valid(dec_valid),
        .dec_ready(dec_ready),
        .dec_op(dec_op),
        .dec_dx(dec_dx),
        .dec_dy(dec_dy),
        .dec_z(dec_z),
        .dec_blank(dec_blank),
        .dec_usez(dec_usez),
        .dec_color(dec_color),
        .dec_lin(dec_lin),
        .dec_bin(dec_bin),
        .dec_scal(dec_scal),
        .busy(busy),
        .halted(halted),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: acknowledges one cycle after a request, ignores reset.
    initial mem_ack = 1'b0;
    initial mem_rdata = 16'h0000;
    always @(posedge clk) begin
        if (mem_req && !mem_ack) begin
            mem_ack   <= 1'b1;
            mem_rdata <= mem[mem_addr];
        end else begin
            mem_ack <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic pushExp(input int id, input logic [2:0] op, input logic [12:0] dx, input logic [12:0] dy,
                           input logic [3:0] z, input logic blank, input logic usez, input logic [2:0] color,
                           input logic [7:0] lin, input logic [2:0] bin, input logic scal);
        exp_t e;
        e.id = id; e.op = op; e.dx = dx; e.dy = dy; e.z = z; e.blank = blank; e.usez = usez;
        e.color = color; e.lin = lin; e.bin = bin; e.scal = scal;
        exp_q.push_back(e);
    endtask

    task automatic pushSimple(input int id, input logic [2:0] op);
        pushExp(id, op, 13'd0, 13'd0, 4'd0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 1'b0);
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] addr);
        @(posedge clk);
        #1;
        start_addr = addr;
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
    endtask

    task automatic waitHalted(input string name, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'd0, halted}, 32'd1);
    endtask

    // Monitor: compare every accepted instruction against the queue head.
    always @(negedge clk) begin
        if (rst_b && dec_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_issue_op", {29'd0, dec_op}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput($sformatf("issue%0d_op", e.id), {29'd0, dec_op}, {29'd0, e.op});
                if (e.op == 3'd0 || e.op == 3'd2) begin
                    checkOutput($sformatf("issue%0d_dx", e.id), {19'd0, dec_dx}, {19'd0, e.dx});
                    checkOutput($sformatf("issue%0d_dy", e.id), {19'd0, dec_dy}, {19'd0, e.dy});
                    checkOutput($sformatf("issue%0d_zbu", e.id), {26'd0, dec_z, dec_blank, dec_usez},
                                {26'd0, e.z, e.blank, e.usez});
                end else if (e.op == 3'd3) begin
                    checkOutput($sformatf("issue%0d_scal", e.id), {31'd0, dec_scal}, {31'd0, e.scal});
                    if (e.scal) begin
                        checkOutput($sformatf("issue%0d_binlin", e.id), {21'd0, dec_bin, dec_lin},
                                    {21'd0, e.bin, e.lin});
                    end else begin
                        checkOutput($sformatf("issue%0d_zcolor", e.id), {25'd0, dec_z, dec_color},
                                    {25'd0, e.z, e.color});
                    end
                end
            end
        end
    end

    // Fetch log: every completed memory read address, in order.
    always @(negedge clk) begin
        if (rst_b && mem_req && mem_ack) begin
            addr_log.push_back(mem_addr);
        end
    end

    // Global watchdog so a stuck DUT still ends the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [ADDR_W-1:0] exp_addr [5];
        int                n;
        logic              found;

        for (int i = 0; i < 8192; i++) mem[i] = 16'h2000;
        // JSR program: main at 0, subroutine at 0x100
        mem[13'h000] = 16'hA100; mem[13'h001] = 16'h8000; mem[13'h002] = 16'h2000;
        mem[13'h100] = 16'h6072; mem[13'h101] = 16'hC000;
        // VCTR then HALT
        mem[13'h010] = 16'h1FFF; mem[13'h011] = 16'h6005; mem[13'h012] = 16'h2000;
        // SVEC then HALT
        mem[13'h030] = 16'h5F9F; mem[13'h031] = 16'h2000;
        // SCAL then HALT (stall test)
        mem[13'h040] = 16'h7305; mem[13'h041] = 16'h2000;
        // Five nested JSRs, then HALT
        mem[13'h050] = 16'hA051; mem[13'h051] = 16'hA052; mem[13'h052] = 16'hA053;
        mem[13'h053] = 16'hA054; mem[13'h054] = 16'hA055; mem[13'h055] = 16'h2000;
        // RTS at top level
        mem[13'h060] = 16'hC000;
        // JMP over a gap to CNTR, HALT
        mem[13'h070] = 16'hE075; mem[13'h075] = 16'h8000; mem[13'h076] = 16'h2000;
        // VCTR used for the mid-fetch reset
        mem[13'h080] = 16'h0001; mem[13'h081] = 16'h4003;

        rst_b = 1'b0; go = 1'b0; start_addr = '0; dec_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_ctrl", {27'd0, mem_req, dec_valid, busy, halted, err}, 32'd0);
        checkOutput("rst_color", {29'd0, dec_color}, 32'd2);
        checkOutput("rst_fields", {3'd0, dec_op, dec_dx, dec_dy}, 32'd0);
        checkOutput("rst_misc", {14'd0, dec_z, dec_blank, dec_usez, dec_lin, dec_bin, dec_scal}, 32'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;

        $display("[TB] VCTR then HALT");
        pushExp(1, 3'd0, 13'h0005, 13'h1FFF, 4'd6, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 1'b0);
        pushSimple(2, 3'd1);
        applyStimulus(13'h010);
        waitHalted("vctr_halted", 100);
        checkOutput("vctr_busy", {31'd0, busy}, 32'd0);
        checkOutput("vctr_drained", exp_q.size(), 32'd0);

        $display("[TB] SVEC");
        pushExp(3, 3'd2, 13'h1FFE, 13'h1FFE, 4'd8, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 1'b0);
        pushSimple(4, 3'd1);
        applyStimulus(13'h030);
        waitHalted("svec_halted", 100);

        $display("[TB] JSR / RTS");
        addr_log.delete();
        pushExp(5, 3'd3, 13'd0, 13'd0, 4'd7, 1'b0, 1'b0, 3'd2, 8'd0, 3'd0, 1'b0);
        pushSimple(6, 3'd4);
        pushSimple(7, 3'd1);
        applyStimulus(13'h000);
        waitHalted("jsr_halted", 200);
        exp_addr[0] = 13'h000; exp_addr[1] = 13'h100; exp_addr[2] = 13'h101;
        exp_addr[3] = 13'h001; exp_addr[4] = 13'h002;
        checkOutput("jsr_fetch_count", addr_log.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < addr_log.size())
                checkOutput($sformatf("jsr_fetch_addr%0d", i), {19'd0, addr_log[i]}, {19'd0, exp_addr[i]});
        end

        $display("[TB] stalled SCAL");
        dec_ready = 1'b0;
        pushExp(8, 3'd3, 13'd0, 13'd0, 4'd0, 1'b0, 1'b0, 3'd0, 8'h05, 3'd3, 1'b1);
        pushSimple(9, 3'd1);
        applyStimulus(13'h040);
        n = 0;
        while (!dec_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stall_valid_rise", {31'd0, dec_valid}, 32'd1);
        applyStimulus(13'h010);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("stall_hold%0d", i),
                        {18'd0, dec_valid, mem_req, dec_scal, dec_bin, dec_lin},
                        {18'd0, 1'b1, 1'b0, 1'b1, 3'd3, 8'h05});
        end
        @(posedge clk);
        #1;
        dec_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("stall_release_req", {18'd0, mem_req, mem_addr}, {18'd0, 1'b1, 13'h041});
        waitHalted("stall_halted", 100);

        $display("[TB] nested JSR");
`ifndef AVG_DEC_STACK_CHECK_EN
        pushSimple(10, 3'd1);
`endif
        applyStimulus(13'h050);
        waitHalted("nest_halted", 200);
`ifdef AVG_DEC_STACK_CHECK_EN
        checkOutput("nest_err", {31'd0, err}, 32'd1);
`else
        checkOutput("nest_err", {31'd0, err}, 32'd0);
`endif
        checkOutput("nest_drained", exp_q.size(), 32'd0);

        $display("[TB] RTS at top level");
`ifndef AVG_DEC_STACK_CHECK_EN
        pushSimple(11, 3'd1);
`endif
        applyStimulus(13'h060);
        checkOutput("rts_err_cleared", {31'd0, err}, 32'd0);
        waitHalted("rts_halted", 200);
`ifdef AVG_DEC_STACK_CHECK_EN
        checkOutput("rts_err", {31'd0, err}, 32'd1);
`else
        checkOutput("rts_err", {31'd0, err}, 32'd0);
`endif
        checkOutput("rts_drained", exp_q.size(), 32'd0);

        $display("[TB] JMP");
        pushSimple(12, 3'd4);
        pushSimple(13, 3'd1);
        applyStimulus(13'h070);
        waitHalted("jmp_halted", 200);

        $display("[TB] reset during FETCH1");
        applyStimulus(13'h080);
        found = 1'b0;
        n = 0;
        while (!found && n < 50) begin
            @(negedge clk);
            n++;
            if (mem_req && !mem_ack && mem_addr == 13'h081) found = 1'b1;
        end
        checkOutput("rst_reach_fetch1", {31'd0, found}, 32'd1);
        rst_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mid_ctrl", {28'd0, mem_req, dec_valid, busy, halted}, 32'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        pushExp(14, 3'd0, 13'h0005, 13'h1FFF, 4'd6, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0, 1'b0);
        pushSimple(15, 3'd1);
        applyStimulus(13'h010);
        waitHalted("restart_halted", 100);
        checkOutput("restart_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
